// File: rtl/buffer_de.sv
// Serial-to-parallel deserializer: collects an LSB-first bit stream into frames
// and drains each completed frame as W-bit words under valid/ready, double buffered.
module buffer_de #(
  parameter int NIBBLES = 16,
  parameter int W       = 4,
  parameter int CONT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         data_in,
  input  logic         ready,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic         frame_done,
  output logic         overrun
);

  localparam int FRAME_BITS = NIBBLES * W;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int IW         = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [CW-1:0]           bit_pos;
  logic                    store;
  logic [FRAME_BITS-1:0]   collect;
  logic [FRAME_BITS-1:0]   frame_word;
  logic [FRAME_BITS-1:0]   hold;
  logic [IW-1:0]           idx;
  logic                    last_bit;
  logic                    take;
  logic                    take_last;
  logic                    hold_free;

  assign last_bit  = (state == COLLECT) && (cnt == CW'(FRAME_BITS - 1));
  assign take      = valid && ready;
  assign take_last = take && (idx == IW'(NIBBLES - 1));
  assign hold_free = !valid || take_last;
  assign store     = (state == COLLECT) || ena;
  assign bit_pos   = (state == IDLE) ? '0 : cnt;

  // The final bit is merged here so the frame can move to hold on the edge that samples it.
  always_comb begin
    frame_word                 = collect;
    frame_word[FRAME_BITS-1]   = data_in;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (ena) begin
          state_nxt = COLLECT;
          cnt_nxt   = CW'(1);
        end
      end
      COLLECT: begin
        if (last_bit) begin
          cnt_nxt = '0;
          if (CONT == 0) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Collect stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      collect <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (store) collect[bit_pos] <= data_in;
    end
  end

  // Hold/drain stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      idx        <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (last_bit && hold_free) begin
        hold       <= frame_word;
        idx        <= '0;
        valid      <= 1'b1;
        frame_done <= 1'b1;
      end else begin
        if (last_bit) overrun <= 1'b1;
        if (take) begin
          if (idx == IW'(NIBBLES - 1)) valid <= 1'b0;
          else                         idx   <= idx + 1'b1;
        end
      end
    end
  end

  assign data_out = valid ? hold[idx*W +: W] : '0;

endmodule

// File: tb/tb_buffer_de.sv
// Directed bench for buffer_de: one continuous-mode and one single-frame-mode instance.
module tb_buffer_de;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena1, din1, rdy1, ena0, din0, rdy0;
  logic [3:0] dout1, dout0;
  logic       vld1, vld0, done1, done0, ovr1, ovr0;

  int checks = 0;
  int errors = 0;
  logic [3:0] words[$];
  int dones;

  logic [63:0] f1, fa, fb, f5, f6;
  logic [3:0]  e_f1[16], e_fa[16], e_fb[16], e_f5[16], e_f6[16];

  typedef struct {
    logic       e;
    logic       d;
    logic       r;
    logic       ev;
    logic       ed;
    logic [3:0] eo;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  buffer_de #(.NIBBLES(16), .W(4), .CONT(1)) d1 (
    .clk(clk), .rst(rst), .ena(ena1), .data_in(din1), .ready(rdy1),
    .data_out(dout1), .valid(vld1), .frame_done(done1), .overrun(ovr1)
  );

  buffer_de #(.NIBBLES(16), .W(4), .CONT(0)) d0 (
    .clk(clk), .rst(rst), .ena(ena0), .data_in(din0), .ready(rdy0),
    .data_out(dout0), .valid(vld0), .frame_done(done0), .overrun(ovr0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic e, input logic d, input logic r);
    if (sel) begin ena1 = e; din1 = d; rdy1 = r; end
    else     begin ena0 = e; din0 = d; rdy0 = r; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, log any word accepted at the coming edge, count frame_done pulses.
  task automatic cyc(input bit sel, input logic e, input logic d, input logic r);
    drive(sel, e, d, r);
    if (sel ? (vld1 && rdy1) : (vld0 && rdy0)) words.push_back(sel ? dout1 : dout0);
    tick();
    if (sel ? done1 : done0) dones++;
  endtask

  task automatic stream(input bit sel, input logic [63:0] f, input bit first_ena,
                        input int mid_ena, input int extra, input logic extra_din);
    for (int i = 0; i < 64; i++) cyc(sel, (first_ena && i == 0) || (i == mid_ena), f[i], 1'b1);
    for (int i = 0; i < extra; i++) cyc(sel, 1'b0, extra_din, 1'b1);
  endtask

  task automatic chk_words(input string tag, input int base, input logic [3:0] exp[16]);
    for (int i = 0; i < 16; i++) begin
      if (base + i < words.size())
        chk($sformatf("%s_word%0d", tag, i), 64'(words[base + i]), 64'(exp[i]));
      else
        chk($sformatf("%s_word%0d_missing", tag, i), 64'hDEAD, 64'(exp[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    words.delete();
    dones = 0;
  endtask

  initial begin
    int w;
    int c;
    logic r;

    f1 = 64'hFEDC_BA98_7654_3210;
    fa = 64'h0123_4567_89AB_CDEF;
    fb = 64'hAAAA_5555_AAAA_5555;
    f5 = 64'h0F1E_2D3C_4B5A_6978;
    f6 = 64'h1357_9BDF_0246_8ACE;
    e_f5 = '{4'h8, 4'h7, 4'h9, 4'h6, 4'hA, 4'h5, 4'hB, 4'h4,
             4'hC, 4'h3, 4'hD, 4'h2, 4'hE, 4'h1, 4'hF, 4'h0};
    e_f6 = '{4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0,
             4'hF, 4'hD, 4'hB, 4'h9, 4'h7, 4'h5, 4'h3, 4'h1};
    for (int i = 0; i < 16; i++) begin
      e_f1[i] = 4'(i);
      e_fa[i] = 4'(15 - i);
      e_fb[i] = ((i / 4) % 2 == 1) ? 4'hA : 4'h5;
    end

    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    dones = 0;
    #1;
    chk("rst_valid1", 64'(vld1), 64'h0);
    chk("rst_dout1", 64'(dout1), 64'h0);
    chk("rst_done1", 64'(done1), 64'h0);
    chk("rst_ovr1", 64'(ovr1), 64'h0);
    chk("rst_valid0", 64'(vld0), 64'h0);
    chk("rst_ovr0", 64'(ovr0), 64'h0);
    tick();
    rst = 1'b0;

    // Test 1: table of per-cycle vectors, ready held high
    for (int i = 0; i < 64; i++)
      tv.push_back('{e: (i == 0), d: f1[i], r: 1'b1, ev: (i == 63), ed: (i == 63), eo: 4'h0});
    for (int k = 1; k < 16; k++)
      tv.push_back('{e: 1'b0, d: 1'b0, r: 1'b1, ev: 1'b1, ed: 1'b0, eo: 4'(k)});
    for (int k = 0; k < 4; k++)
      tv.push_back('{e: 1'b0, d: 1'b0, r: 1'b1, ev: 1'b0, ed: 1'b0, eo: 4'h0});
    for (int i = 0; i < tv.size(); i++) begin
      drive(1'b1, tv[i].e, tv[i].d, tv[i].r);
      tick();
      chk($sformatf("t1_valid[%0d]", i), 64'(vld1), 64'(tv[i].ev));
      chk($sformatf("t1_dout[%0d]", i), 64'(dout1), 64'(tv[i].eo));
      chk($sformatf("t1_done[%0d]", i), 64'(done1), 64'(tv[i].ed));
    end

    // Test 2: ready toggling during drain
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, i == 0, f1[i], (i % 2) == 0);
    chk("t2_done", 64'(done1), 64'h1);
    w = 0;
    c = 0;
    while (w < 16 && c < 100) begin
      r = (c % 2) == 0;
      chk($sformatf("t2_valid_c%0d", c), 64'(vld1), 64'h1);
      chk($sformatf("t2_dout_c%0d", c), 64'(dout1), 64'(w));
      drive(1'b1, 1'b0, 1'b0, r);
      tick();
      if (r) w++;
      c++;
    end
    chk("t2_all_words", 64'(w), 64'd16);
    chk("t2_valid_after", 64'(vld1), 64'h0);

    // Test 3: back-to-back frames in continuous mode
    do_reset();
    stream(1'b1, fa, 1'b1, -1, 0, 1'b0);
    stream(1'b1, fb, 1'b0, -1, 20, 1'b0);
    chk("t3_nwords", 64'(words.size()), 64'd32);
    chk("t3_dones", 64'(dones), 64'd2);
    chk_words("t3_a", 0, e_fa);
    chk_words("t3_b", 16, e_fb);
    chk("t3_ovr", 64'(ovr1), 64'h0);

    // Test 4: overrun while the hold buffer stalls
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1'b1, i == 0, f1[i], 1'b0);
    chk("t4_done", 64'(done1), 64'h1);
    for (int i = 0; i < 130; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      if (i == 62) chk("t4_ovr_before", 64'(ovr1), 64'h0);
      if (i == 63) chk("t4_ovr_set", 64'(ovr1), 64'h1);
    end
    chk("t4_valid_held", 64'(vld1), 64'h1);
    chk("t4_dout_held", 64'(dout1), 64'h0);
    words.delete();
    for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t4_nwords", 64'(words.size()), 64'd16);
    chk_words("t4", 0, e_f1);
    chk("t4_valid_after", 64'(vld1), 64'h0);
    chk("t4_ovr_sticky", 64'(ovr1), 64'h1);

    // Test 5: reset mid-collect, idle stream afterwards
    do_reset();
    for (int i = 0; i < 30; i++) cyc(1'b1, i == 0, f1[i], 1'b1);
    drive(1'b1, 1'b0, f1[30], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid_in_rst", 64'(vld1), 64'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b0, 1'($urandom), 1'b1);
      chk($sformatf("t5_valid[%0d]", i), 64'(vld1), 64'h0);
      chk($sformatf("t5_done[%0d]", i), 64'(done1), 64'h0);
    end
    words.delete();
    dones = 0;
    stream(1'b1, f5, 1'b1, -1, 20, 1'b0);
    chk("t5_dones", 64'(dones), 64'd1);
    chk("t5_nwords", 64'(words.size()), 64'd16);
    chk_words("t5", 0, e_f5);

    // Test 6: single-frame mode, stray ena mid-frame, trailing bits ignored
    do_reset();
    stream(1'b0, f6, 1'b1, 20, 64, 1'b1);
    chk("t6_dones", 64'(dones), 64'd1);
    chk("t6_nwords", 64'(words.size()), 64'd16);
    chk_words("t6", 0, e_f6);
    chk("t6_valid_idle", 64'(vld0), 64'h0);
    words.delete();
    dones = 0;
    stream(1'b0, f1, 1'b1, -1, 20, 1'b0);
    chk("t6_second_dones", 64'(dones), 64'd1);
    chk("t6_second_nwords", 64'(words.size()), 64'd16);
    chk_words("t6_second", 0, e_f1);
    chk("t6_ovr", 64'(ovr0), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
